// File: rtl/morse_encoder_fsm_if.sv
// Character handshake between a text source and the Morse encoder.
// The source drives char_in/char_valid; the encoder answers with char_ready.
interface morse_encoder_fsm_if;
    logic [5:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/morse_encoder_fsm.sv
// Morse encoder: takes one character code per valid/ready handshake and keys
// line b with ITU timing (dot 1, dash 3, element gap 1, letter gap 3, word gap 7
// units). A unit is UNIT_CYCLES clock cycles.
module morse_encoder_fsm #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    morse_encoder_fsm_if.slave   char_if,
    output logic                 b,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned CW = $clog2(UNIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_ESPACE,
        S_LGAP,
        S_WGAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    unit_cnt;
    logic [2:0]    elem_idx;
    logic [4:0]    pat;

    logic          unit_tick;
    logic          seg_done;
    logic          ready_int;
    logic          accept;
    logic          code_is_char;
    logic          code_is_space;
    logic [2:0]    lut_len;
    logic [4:0]    lut_pat;

    // Letter/digit table: element count and left-aligned pattern, 1 = dash.
    always_comb begin
        lut_len = 3'd0;
        lut_pat = 5'b00000;
        case (char_if.char_in)
            6'd0:  begin lut_len = 3'd2; lut_pat = 5'b01000; end // A .-
            6'd1:  begin lut_len = 3'd4; lut_pat = 5'b10000; end // B -...
            6'd2:  begin lut_len = 3'd4; lut_pat = 5'b10100; end // C -.-.
            6'd3:  begin lut_len = 3'd3; lut_pat = 5'b10000; end // D -..
            6'd4:  begin lut_len = 3'd1; lut_pat = 5'b00000; end // E .
            6'd5:  begin lut_len = 3'd4; lut_pat = 5'b00100; end // F ..-.
            6'd6:  begin lut_len = 3'd3; lut_pat = 5'b11000; end // G --.
            6'd7:  begin lut_len = 3'd4; lut_pat = 5'b00000; end // H ....
            6'd8:  begin lut_len = 3'd2; lut_pat = 5'b00000; end // I ..
            6'd9:  begin lut_len = 3'd4; lut_pat = 5'b01110; end // J .---
            6'd10: begin lut_len = 3'd3; lut_pat = 5'b10100; end // K -.-
            6'd11: begin lut_len = 3'd4; lut_pat = 5'b01000; end // L .-..
            6'd12: begin lut_len = 3'd2; lut_pat = 5'b11000; end // M --
            6'd13: begin lut_len = 3'd2; lut_pat = 5'b10000; end // N -.
            6'd14: begin lut_len = 3'd3; lut_pat = 5'b11100; end // O ---
            6'd15: begin lut_len = 3'd4; lut_pat = 5'b01100; end // P .--.
            6'd16: begin lut_len = 3'd4; lut_pat = 5'b11010; end // Q --.-
            6'd17: begin lut_len = 3'd3; lut_pat = 5'b01000; end // R .-.
            6'd18: begin lut_len = 3'd3; lut_pat = 5'b00000; end // S ...
            6'd19: begin lut_len = 3'd1; lut_pat = 5'b10000; end // T -
            6'd20: begin lut_len = 3'd3; lut_pat = 5'b00100; end // U ..-
            6'd21: begin lut_len = 3'd4; lut_pat = 5'b00010; end // V ...-
            6'd22: begin lut_len = 3'd3; lut_pat = 5'b01100; end // W .--
            6'd23: begin lut_len = 3'd4; lut_pat = 5'b10010; end // X -..-
            6'd24: begin lut_len = 3'd4; lut_pat = 5'b10110; end // Y -.--
            6'd25: begin lut_len = 3'd4; lut_pat = 5'b11000; end // Z --..
            6'd26: begin lut_len = 3'd5; lut_pat = 5'b11111; end // 0 -----
            6'd27: begin lut_len = 3'd5; lut_pat = 5'b01111; end // 1 .----
            6'd28: begin lut_len = 3'd5; lut_pat = 5'b00111; end // 2 ..---
            6'd29: begin lut_len = 3'd5; lut_pat = 5'b00011; end // 3 ...--
            6'd30: begin lut_len = 3'd5; lut_pat = 5'b00001; end // 4 ....-
            6'd31: begin lut_len = 3'd5; lut_pat = 5'b00000; end // 5 .....
            6'd32: begin lut_len = 3'd5; lut_pat = 5'b10000; end // 6 -....
            6'd33: begin lut_len = 3'd5; lut_pat = 5'b11000; end // 7 --...
            6'd34: begin lut_len = 3'd5; lut_pat = 5'b11100; end // 8 ---..
            6'd35: begin lut_len = 3'd5; lut_pat = 5'b11110; end // 9 ----.
            default: begin lut_len = 3'd0; lut_pat = 5'b00000; end
        endcase
    end

    assign code_is_char  = (char_if.char_in < 6'd36);
    assign code_is_space = (char_if.char_in == 6'd36);

    assign unit_tick = (cyc_cnt == CW'(UNIT_CYCLES - 1));
    assign seg_done  = unit_tick && (unit_cnt == 3'd1);

    // Ready in idle and in the last cycle of a gap, so streamed characters keep exact spacing.
    assign ready_int = (state == S_IDLE) ||
                       (((state == S_LGAP) || (state == S_WGAP)) && seg_done);
    assign char_if.char_ready = ready_int;
    assign accept             = char_if.char_valid && ready_int;
    assign busy               = (state != S_IDLE);

    // Keying FSM with unit prescaler, segment duration counter and element shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            b        <= 1'b0;
            err      <= 1'b0;
            cyc_cnt  <= '0;
            unit_cnt <= '0;
            elem_idx <= '0;
            pat      <= '0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                cyc_cnt <= '0;
                if (code_is_char) begin
                    state    <= S_MARK;
                    b        <= 1'b1;
                    pat      <= lut_pat;
                    elem_idx <= lut_len;
                    unit_cnt <= lut_pat[4] ? 3'd3 : 3'd1;
                end else if (code_is_space) begin
                    state    <= S_WGAP;
                    b        <= 1'b0;
                    unit_cnt <= 3'd4;
                end else begin
                    state    <= S_IDLE;
                    b        <= 1'b0;
                    err      <= 1'b1;
                end
            end else if (state != S_IDLE) begin
                if (seg_done) begin
                    cyc_cnt <= '0;
                    case (state)
                        S_MARK: begin
                            b <= 1'b0;
                            if (elem_idx > 3'd1) begin
                                state    <= S_ESPACE;
                                unit_cnt <= 3'd1;
                                elem_idx <= elem_idx - 3'd1;
                                pat      <= {pat[3:0], 1'b0};
                            end else begin
                                state    <= S_LGAP;
                                unit_cnt <= 3'd3;
                            end
                        end
                        S_ESPACE: begin
                            state    <= S_MARK;
                            b        <= 1'b1;
                            unit_cnt <= pat[4] ? 3'd3 : 3'd1;
                        end
                        default: begin
                            state    <= S_IDLE;
                            b        <= 1'b0;
                            unit_cnt <= 3'd0;
                        end
                    endcase
                end else begin
                    cyc_cnt <= unit_tick ? '0 : cyc_cnt + CW'(1);
                    if (unit_tick) begin
                        unit_cnt <= unit_cnt - 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_morse_encoder_fsm.sv
// Bench for morse_encoder_fsm: directed and random character streams checked
// cycle by cycle against a timeline model built from dot/dash strings.
module tb_morse_encoder_fsm;

    localparam int unsigned U = 4;

    logic clk = 1'b0;
    logic reset;
    logic b;
    logic busy;
    logic err;

    morse_encoder_fsm_if cif();

    morse_encoder_fsm #(.UNIT_CYCLES(U)) dut (
        .clk     (clk),
        .reset   (reset),
        .char_if (cif),
        .b       (b),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int idle;
    } item_t;

    string morse_tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    int    tests = 0;
    int    fails = 0;
    int    s     = -1;
    int    end_s = -1;
    int    rst_at = -100;
    bit    exp_bq [$];
    bit    err_next = 1'b0;
    bit    taken = 1'b0;
    bit    rand_phase = 1'b0;
    bit    o_reset_done = 1'b0;
    item_t stim_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s sample %0d: got %0d expected %0d", tag, s, got, exp);
        end
    endtask

    task automatic add(input int code, input int idle);
        item_t it;
        it.code = code;
        it.idle = idle;
        stim_q.push_back(it);
    endtask

    // Timeline model: expected b levels for the samples following an accept.
    task automatic model_accept(input int code);
        string m;
        int    n;
        if (code < 36) begin
            m = morse_tab[code];
            for (int i = 0; i < m.len(); i++) begin
                n = (m.getc(i) == 8'h2D) ? 3 : 1;
                repeat (n * U) exp_bq.push_back(1'b1);
                if (i < m.len() - 1) repeat (U) exp_bq.push_back(1'b0);
            end
            repeat (3 * U) exp_bq.push_back(1'b0);
            end_s = s + exp_bq.size();
        end else if (code == 36) begin
            repeat (4 * U) exp_bq.push_back(1'b0);
            end_s = s + 4 * U;
        end else begin
            err_next = 1'b1;
        end
    endtask

    task automatic step();
        bit    eb;
        bit    eerr;
        bit    do_rst;
        item_t it;
        @(negedge clk);
        s++;
        eb   = (exp_bq.size() > 0) ? exp_bq.pop_front() : 1'b0;
        eerr = err_next;
        err_next = 1'b0;
        check("b", 32'(b), 32'(eb));
        check("busy", 32'(busy), 32'(s <= end_s));
        check("char_ready", 32'(cif.char_ready), 32'(s >= end_s));
        check("err", 32'(err), 32'(eerr));

        if (taken) begin
            cif.char_valid = 1'b0;
            taken = 1'b0;
        end
        if (!cif.char_valid) begin
            cif.char_in = 6'($urandom);
            if (stim_q.size() > 0) begin
                if (stim_q[0].idle > 0) begin
                    stim_q[0].idle = stim_q[0].idle - 1;
                end else begin
                    it = stim_q.pop_front();
                    cif.char_in    = 6'(it.code);
                    cif.char_valid = 1'b1;
                end
            end
        end

        do_rst = (s == rst_at) || (rand_phase && ($urandom_range(0, 149) == 0));
        reset = do_rst;
        if (do_rst) begin
            exp_bq.delete();
            end_s = s;
        end else if (cif.char_valid && (s >= end_s)) begin
            model_accept(int'(cif.char_in));
            taken = 1'b1;
            if ((cif.char_in == 6'd14) && !o_reset_done) begin
                rst_at = s + 6;
                o_reset_done = 1'b1;
            end
        end
    endtask

    initial begin
        int guard;
        reset          = 1'b1;
        cif.char_valid = 1'b0;
        cif.char_in    = 6'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        add(4, 2);                   // E alone
        add(0, 5);                   // A
        add(19, 3);                  // T
        add(4, 3);  add(4, 0);       // E,E back to back
        add(4, 3);  add(36, 0); add(4, 0);  // E, word space, E
        add(50, 3);                  // invalid code
        add(14, 3); add(4, 0);       // O aborted by reset, then E

        guard = 0;
        while ((stim_q.size() > 0) && (guard < 5000)) begin
            step();
            guard++;
        end

        rand_phase = 1'b1;
        for (int i = 0; i < 60; i++) begin
            add(($urandom_range(0, 9) == 0) ? int'($urandom_range(36, 63)) : int'($urandom_range(0, 35)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));
        end
        guard = 0;
        while ((stim_q.size() > 0) && (guard < 40000)) begin
            step();
            guard++;
        end
        rand_phase = 1'b0;

        guard = 0;
        while ((cif.char_valid || (s <= end_s)) && (guard < 500)) begin
            step();
            guard++;
        end
        repeat (4) step();
        check("drain_pending", 32'(stim_q.size()), 32'd0);
        check("drain_valid", 32'(cif.char_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
